// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low row drive, synchronised column read,
// press/release debounce, and a 32-bit nibble entry shift register.
module keypad_scan #(
   parameter int SCAN_DIV = 16,
   parameter int DEBOUNCE = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  col,
   input  logic        clear,
   output logic [3:0]  row,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [31:0] data
);

   localparam int DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     col_meta_q, col_s_q;
   logic [1:0]     row_idx_q, row_idx_d;
   logic [DW-1:0]  dwell_q, dwell_d;
   logic [DBW-1:0] deb_q, deb_d;
   logic [3:0]     cap_col_q, cap_col_d;
   logic [3:0]     cap_code_q, cap_code_d;
   logic [3:0]     key_code_q, key_code_d;
   logic           key_valid_q, key_valid_d;
   logic           key_held_q, key_held_d;
   logic [31:0]    data_q, data_d;
   logic [1:0]     col_idx;
   logic [31:0]    data_base;

   // Lowest-numbered low column wins when several are pressed together.
   always_comb begin
      col_idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!col_s_q[i]) col_idx = 2'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      dwell_d     = dwell_q;
      deb_d       = deb_q;
      cap_col_d   = cap_col_q;
      cap_code_d  = cap_code_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      data_base   = clear ? 32'h0 : data_q;
      data_d      = data_base;

      case (state_q)
         ST_SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               if (col_s_q != 4'b1111) begin
                  cap_col_d  = col_s_q;
                  cap_code_d = {row_idx_q, col_idx};
                  deb_d      = '0;
                  state_d    = ST_DEBOUNCE;
               end else begin
                  row_idx_d = row_idx_q + 2'd1;
                  dwell_d   = '0;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (col_s_q == cap_col_q) begin
               if (deb_q == DEB_LAST) begin
                  key_code_d  = cap_code_q;
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
                  data_d      = {data_base[27:0], cap_code_q};
                  state_d     = ST_PRESSED;
               end else begin
                  deb_d = deb_q + DBW'(1);
               end
            end else begin
               dwell_d = '0;
               state_d = ST_SCAN;
            end
         end
         ST_PRESSED: begin
            if (col_s_q == 4'b1111) begin
               deb_d   = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (col_s_q == 4'b1111) begin
               if (deb_q == DEB_LAST) begin
                  key_held_d = 1'b0;
                  row_idx_d  = row_idx_q + 2'd1;
                  dwell_d    = '0;
                  state_d    = ST_SCAN;
               end else begin
                  deb_d = deb_q + DBW'(1);
               end
            end else begin
               state_d = ST_PRESSED;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SCAN;
         col_meta_q  <= 4'b1111;
         col_s_q     <= 4'b1111;
         row_idx_q   <= 2'd0;
         dwell_q     <= '0;
         deb_q       <= '0;
         cap_col_q   <= 4'b1111;
         cap_code_q  <= 4'h0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
         data_q      <= 32'h0;
      end else begin
         state_q     <= state_d;
         col_meta_q  <= col;
         col_s_q     <= col_meta_q;
         row_idx_q   <= row_idx_d;
         dwell_q     <= dwell_d;
         deb_q       <= deb_d;
         cap_col_q   <= cap_col_d;
         cap_code_q  <= cap_code_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
         data_q      <= data_d;
      end
   end

   assign row       = ~(4'b0001 << row_idx_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;
   assign data      = data_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomised and directed keypad presses; a scoreboard queue of expected
// (code, data) pairs is drained by a monitor on every key_valid pulse.
module tb_keypad_scan;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [31:0] data;

   always #5 clk = ~clk;

   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk(clk), .rst(rst), .col(col), .clear(clear), .row(row),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .data(data)
   );

   // Keypad model: a pressed key (r,c) pulls column c low while row r is driven.
   logic [15:0] pressed;
   always_comb begin
      col = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[4*r+c] && !row[r]) col[c] = 1'b0;
   end

   typedef struct packed {
      logic [3:0]  code;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          passes = 0;
   logic [31:0] data_m;
   bit          ok;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h required %h", name, act, req);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse must match the oldest expected press.
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_valid = 1'b0;
         end else begin
            if (key_valid) begin
               check("pulse_width", {31'h0, prev_valid}, 32'h0);
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_pulse: got code %h data %h required no pulse", key_code, data);
               end else begin
                  e = exp_q.pop_front();
                  $display("pulse code=%h data=%h", key_code, data);
                  check("key_code", {28'h0, key_code}, {28'h0, e.code});
                  check("data", data, e.data);
               end
            end
            prev_valid = key_valid;
         end
      end
   end

   task automatic expect_key(input logic [3:0] code);
      data_m = {data_m[27:0], code};
      exp_q.push_back('{code: code, data: data_m});
   endtask

   // Press the keys in mask (optionally with bounce and release glitches),
   // release, and confirm the pulse was seen and key_held dropped.
   task automatic do_press(input logic [15:0] mask, input logic [3:0] code,
                           input bit bounce, input bit glitch);
      expect_key(code);
      if (bounce) begin
         repeat (6) begin
            pressed = pressed ^ mask;
            tick(1);
         end
      end
      pressed = pressed | mask;
      tick(40);
      if (glitch) begin
         repeat (2) begin
            pressed = pressed & ~mask;
            tick(2);
            pressed = pressed | mask;
            tick(3);
         end
      end
      check("held_while_pressed", {31'h0, key_held}, 32'h1);
      pressed = pressed & ~mask;
      tick(12);
      check("held_after_release", {31'h0, key_held}, 32'h0);
      check("pulse_seen", exp_q.size(), 32'h0);
   endtask

   task automatic wait_row(input logic [3:0] target, output bit found);
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (row == target) begin
            found = 1'b1;
            break;
         end
         tick(1);
      end
      if (!found) begin
         checks++;
         $display("FAIL wait_row: got %b required %b", row, target);
      end
   endtask

   initial begin
      rst = 1'b1;
      clear = 1'b0;
      pressed = 16'h0;
      data_m = 32'h0;
      tick(3);
      check("rst_row", {28'h0, row}, 32'he);
      check("rst_key_code", {28'h0, key_code}, 32'h0);
      check("rst_key_valid", {31'h0, key_valid}, 32'h0);
      check("rst_key_held", {31'h0, key_held}, 32'h0);
      check("rst_data", data, 32'h0);
      rst = 1'b0;

      // Idle: the driven row advances every SCAN_DIV cycles.
      for (int k = 1; k <= 40; k++) begin
         logic [3:0] er;
         tick(1);
         er = 4'b1111 ^ (4'b0001 << ((k / SCAN_DIV) % 4));
         check("idle_row", {28'h0, row}, {28'h0, er});
      end
      check("idle_data", data, 32'h0);

      // Key 9, then clear, then 1,2,3,A.
      do_press(16'h1 << 9, 4'h9, 1'b0, 1'b0);
      check("data_9", data, 32'h9);
      clear = 1'b1; tick(1); clear = 1'b0; data_m = 32'h0;
      check("data_cleared", data, 32'h0);
      do_press(16'h1 << 1, 4'h1, 1'b0, 1'b0);
      do_press(16'h1 << 2, 4'h2, 1'b0, 1'b0);
      do_press(16'h1 << 3, 4'h3, 1'b0, 1'b0);
      do_press(16'h1 << 10, 4'hA, 1'b0, 1'b0);
      check("data_123A", data, 32'h123A);

      // Row1, columns 1 and 3 together -> code 5.
      do_press((16'h1 << 5) | (16'h1 << 7), 4'h5, 1'b0, 1'b0);
      // Bouncy press and glitchy release -> single pulse.
      do_press(16'h1 << 6, 4'h6, 1'b1, 1'b1);

      // A second key pressed while the first is held is ignored.
      expect_key(4'h1);
      pressed = 16'h1 << 1;
      tick(40);
      pressed = pressed | (16'h1 << 14);
      tick(10);
      check("held_other_key", {31'h0, key_held}, 32'h1);
      pressed = 16'h1 << 1;
      tick(10);
      pressed = 16'h0;
      tick(12);
      check("other_key_ignored", exp_q.size(), 32'h0);

      for (int i = 0; i < 12; i++) begin
         int k;
         k = $urandom_range(0, 15);
         do_press(16'h1 << k, 4'(k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      clear = 1'b1; tick(1); clear = 1'b0; data_m = 32'h0;
      for (int k = 1; k <= 8; k++) do_press(16'h1 << k, 4'(k), 1'b0, 1'b0);
      check("data_12345678", data, 32'h12345678);

      // Key F accepted SCAN_DIV + DEBOUNCE cycles after row3 starts; clear in that cycle.
      wait_row(4'b1011, ok);
      pressed = 16'h1 << 15;
      wait_row(4'b0111, ok);
      tick(6);
      clear = 1'b1;
      exp_q.push_back('{code: 4'hF, data: 32'hF});
      data_m = 32'hF;
      tick(1);
      clear = 1'b0;
      tick(30);
      pressed = 16'h0;
      tick(12);
      check("clear_shift_data", data, 32'hF);
      check("clear_shift_seen", exp_q.size(), 32'h0);

      // Reset in the middle of a press debounce.
      wait_row(4'b1011, ok);
      pressed = 16'h1 << 15;
      wait_row(4'b0111, ok);
      tick(5);
      rst = 1'b1;
      #1;
      check("mid_rst_row", {28'h0, row}, 32'he);
      check("mid_rst_key_code", {28'h0, key_code}, 32'h0);
      check("mid_rst_key_valid", {31'h0, key_valid}, 32'h0);
      check("mid_rst_key_held", {31'h0, key_held}, 32'h0);
      check("mid_rst_data", data, 32'h0);
      pressed = 16'h0;
      data_m = 32'h0;
      tick(2);
      rst = 1'b0;
      tick(40);
      check("post_rst_data", data, 32'h0);
      check("post_rst_held", {31'h0, key_held}, 32'h0);
      check("scoreboard_drained", exp_q.size(), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
